// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter slice.
// Holds shift-type encodings, the request bundle and a saturating increment.
package shift_pkg;

  localparam logic [1:0] SHIFT_SLLI = 2'b00;
  localparam logic [1:0] SHIFT_SRLI = 2'b01;
  localparam logic [1:0] SHIFT_SRAI = 2'b10;
  localparam logic [1:0] SHIFT_PASS = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
  } shift_req_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/barrelshifter.sv
// 32-bit barrel shifter: SLLI / SRLI / SRAI / pass-through.
// Ports: req (operand, shamt, op) in; result out (combinational).
module barrelshifter
  import shift_pkg::*;
(
  input  shift_req_t  req,
  output logic [31:0] result
);

  always_comb begin
    result = req.data;
    unique case (req.op)
      SHIFT_SLLI: result = req.data << req.shamt;
      SHIFT_SRLI: result = req.data >> req.shamt;
      SHIFT_SRAI: result = $unsigned($signed(req.data) >>> req.shamt);
      SHIFT_PASS: result = req.data;
      default:    result = req.data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters.
// Ports: clk, rst_n, req0_*/req1_* valid/ready/data/shamt/type/tag,
// rsp_valid/ready/data/src/tag; with SHIFT_ARB_PERF_EN also perf_clr and
// perf_grant0/1, perf_stall0/1 saturating 16-bit counters.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int RESET_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [4:0]       req0_shamt,
  input  logic [1:0]       req0_type,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [4:0]       req1_shamt,
  input  logic [1:0]       req1_type,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag
`ifdef SHIFT_ARB_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [15:0]      perf_grant0,
  output logic [15:0]      perf_grant1,
  output logic [15:0]      perf_stall0,
  output logic [15:0]      perf_stall1
`endif
);

  localparam logic PRIO0 = (RESET_PRIO != 0);

  logic [1:0]  rst_q;
  logic        run;
  logic        ptr;
  logic        free;
  logic        gnt0;
  logic        gnt1;
  logic        acc;
  shift_req_t  win;
  logic [31:0] shifted;

  // Deassertion is synchronised; assertion clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign run  = rst_q[1];
  assign free = run && (!rsp_valid || rsp_ready);

  assign gnt0 = free && req0_valid && (!req1_valid || !ptr);
  assign gnt1 = free && req1_valid && (!req0_valid || ptr);
  assign acc  = gnt0 || gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign win = gnt1
    ? '{data: req1_data, shamt: req1_shamt, op: req1_type}
    : '{data: req0_data, shamt: req0_shamt, op: req0_type};

  barrelshifter u_shift (
    .req    (win),
    .result (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= PRIO0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_src   <= 1'b0;
      rsp_tag   <= '0;
    end else if (acc) begin
      ptr       <= gnt0;
      rsp_valid <= 1'b1;
      rsp_data  <= shifted;
      rsp_src   <= gnt1;
      rsp_tag   <= gnt1 ? req1_tag : req0_tag;
    end else if (free) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef SHIFT_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall0 <= '0;
      perf_stall1 <= '0;
    end else if (perf_clr) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall0 <= '0;
      perf_stall1 <= '0;
    end else begin
      if (gnt0)
        perf_grant0 <= sat_inc(perf_grant0);
      if (gnt1)
        perf_grant1 <= sat_inc(perf_grant1);
      if (req0_valid && !gnt0)
        perf_stall0 <= sat_inc(perf_stall0);
      if (req1_valid && !gnt1)
        perf_stall1 <= sat_inc(perf_stall1);
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed + randomized self-checking bench for shift_arbiter.
// Perf counter checks compile in only with SHIFT_ARB_PERF_EN.
module tb_shift_arbiter;

  localparam int TAG_W = 4;
  localparam int PRIO  = 0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_data, req1_data;
  logic [4:0]       req0_shamt, req1_shamt;
  logic [1:0]       req0_type, req1_type;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;
`ifdef SHIFT_ARB_PERF_EN
  logic             perf_clr;
  logic [15:0]      perf_grant0, perf_grant1;
  logic [15:0]      perf_stall0, perf_stall1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.TAG_W(TAG_W), .RESET_PRIO(PRIO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_type  (req0_type),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_type  (req1_type),
    .req1_tag   (req1_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_src    (rsp_src),
    .rsp_tag    (rsp_tag)
`ifdef SHIFT_ARB_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .perf_grant0 (perf_grant0),
    .perf_grant1 (perf_grant1),
    .perf_stall0 (perf_stall0),
    .perf_stall1 (perf_stall1)
`endif
  );

  // Reference shift built bit by bit from the textual rules.
  function automatic logic [31:0] ref_shift(
    input logic [31:0] d,
    input int          sh,
    input logic [1:0]  op
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      case (op)
        2'b00:   r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        2'b01:   r[i] = (i + sh <= 31) ? d[i+sh] : 1'b0;
        2'b10:   r[i] = (i + sh <= 31) ? d[i+sh] : d[31];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(
    input logic v, input logic [31:0] d, input logic [4:0] s,
    input logic [1:0] t, input logic [3:0] g
  );
    req0_valid = v; req0_data = d; req0_shamt = s;
    req0_type = t;  req0_tag = g;
  endtask

  task automatic set1(
    input logic v, input logic [31:0] d, input logic [4:0] s,
    input logic [1:0] t, input logic [3:0] g
  );
    req1_valid = v; req1_data = d; req1_shamt = s;
    req1_type = t;  req1_tag = g;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic single(
    input string n, input logic [31:0] d, input logic [4:0] s,
    input logic [1:0] t, input logic [31:0] e
  );
    set0(1'b1, d, s, t, 4'h9);
    tick();
    chk({n, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({n, "_data"}, rsp_data, e);
  endtask

  // Model state for the randomized phase.
  logic        m_valid, m_src, m_pref;
  logic [31:0] m_data;
  logic [3:0]  m_tag;
  logic        e0, e1, mfree;

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
`ifdef SHIFT_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    set0(1'b1, 32'h0, 5'd0, 2'b00, 4'h0);
    set1(1'b1, 32'h0, 5'd0, 2'b00, 4'h0);
    #12;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_src", 32'(rsp_src), 32'd0);
    chk("rst_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    set0(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
    set1(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
    rst_n = 1'b1;
    tick();
    tick();

    // Contention from reset: grants alternate starting at port 0.
    set0(1'b1, 32'h1111_1111, 5'd3, 2'b11, 4'h1);
    set1(1'b1, 32'h0000_0001, 5'd31, 2'b00, 4'h2);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_rdy0", 32'(req0_ready), 32'(k % 2 == 0));
      chk("rr_rdy1", 32'(req1_ready), 32'(k % 2 == 1));
      tick();
      chk("rr_src", 32'(rsp_src), 32'(k % 2));
      chk("rr_data", rsp_data,
          (k % 2) ? 32'h8000_0000 : 32'h1111_1111);
      chk("rr_tag", 32'(rsp_tag), (k % 2) ? 32'd2 : 32'd1);
    end
    set1(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);

    // Single port-0 SRAI.
    set0(1'b1, 32'h8000_0010, 5'd4, 2'b10, 4'h3);
    tick();
    chk("srai_valid", 32'(rsp_valid), 32'd1);
    chk("srai_data", rsp_data, 32'hF800_0001);
    chk("srai_src", 32'(rsp_src), 32'd0);
    chk("srai_tag", 32'(rsp_tag), 32'd3);

    // Backpressure with 0xF0 pending.
    set0(1'b1, 32'h0000_00F0, 5'd0, 2'b11, 4'h4);
    tick();
    chk("bp_first", rsp_data, 32'h0000_00F0);
    set0(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
    set1(1'b1, 32'h0000_0100, 5'd4, 2'b01, 4'h5);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy0", 32'(req0_ready), 32'd0);
      chk("bp_rdy1", 32'(req1_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'h0000_00F0);
      chk("bp_src", 32'(rsp_src), 32'd0);
      chk("bp_tag", 32'(rsp_tag), 32'd4);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_b2b_rdy1", 32'(req1_ready), 32'd1);
    tick();
    chk("bp_b2b_data", rsp_data, 32'h0000_0010);
    chk("bp_b2b_src", 32'(rsp_src), 32'd1);
    chk("bp_b2b_tag", 32'(rsp_tag), 32'd5);
    set1(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);

    // Edge cases.
    single("sh0_slli", 32'hDEAD_BEEF, 5'd0, 2'b00, 32'hDEAD_BEEF);
    single("sh0_srli", 32'hDEAD_BEEF, 5'd0, 2'b01, 32'hDEAD_BEEF);
    single("sh0_srai", 32'hDEAD_BEEF, 5'd0, 2'b10, 32'hDEAD_BEEF);
    single("sh0_pass", 32'hDEAD_BEEF, 5'd0, 2'b11, 32'hDEAD_BEEF);
    single("pass7", 32'hDEAD_BEEF, 5'd7, 2'b11, 32'hDEAD_BEEF);
    single("srli31", 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001);
    set0(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);

    // Reset mid-operation with a result pending under backpressure.
    set1(1'b1, 32'h0000_0F00, 5'd4, 2'b01, 4'h6);
    tick();
    rsp_ready = 1'b0;
    set1(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
    tick();
    chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(rsp_valid), 32'd0);
    set0(1'b1, 32'h1, 5'd1, 2'b00, 4'h7);
    set1(1'b1, 32'h1, 5'd2, 2'b00, 4'h8);
    #4;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("mid_prio_rdy0", 32'(req0_ready), 32'(PRIO == 0));
    chk("mid_prio_rdy1", 32'(req1_ready), 32'(PRIO == 1));
    set0(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
    set1(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);

    // Randomized traffic against the model.
    do_reset();
    m_valid = 1'b0;
    m_pref  = (PRIO != 0);
    m_data  = '0;
    m_src   = 1'b0;
    m_tag   = '0;
    e0 = 1'b0;
    e1 = 1'b0;
    for (int k = 0; k < 300; k++) begin
      // Keep operands while a request waits; valid may still drop.
      if (!(req0_valid && !e0))
        set0(1'b0, $urandom, 5'($urandom), 2'($urandom), 4'($urandom));
      if (!(req1_valid && !e1))
        set1(1'b0, $urandom, 5'($urandom), 2'($urandom), 4'($urandom));
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      rsp_ready  = ($urandom_range(0, 2) != 0);
      #1;
      mfree = !m_valid || rsp_ready;
      if (req0_valid && req1_valid) begin
        e0 = mfree && !m_pref;
        e1 = mfree && m_pref;
      end else begin
        e0 = mfree && req0_valid;
        e1 = mfree && req1_valid;
      end
      chk("rnd_rdy0", 32'(req0_ready), 32'(e0));
      chk("rnd_rdy1", 32'(req1_ready), 32'(e1));
      if (e0 || e1) begin
        m_valid = 1'b1;
        m_src   = e1;
        m_pref  = e0;
        m_data  = e1
          ? ref_shift(req1_data, int'(req1_shamt), req1_type)
          : ref_shift(req0_data, int'(req0_shamt), req0_type);
        m_tag   = e1 ? req1_tag : req0_tag;
      end else if (mfree) begin
        m_valid = 1'b0;
      end
      tick();
      chk("rnd_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_data", rsp_data, m_data);
        chk("rnd_src", 32'(rsp_src), 32'(m_src));
        chk("rnd_tag", 32'(rsp_tag), 32'(m_tag));
      end
    end
    set0(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
    set1(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
    rsp_ready = 1'b1;
    tick();

`ifdef SHIFT_ARB_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr_g0", 32'(perf_grant0), 32'd0);
    chk("perf_clr_s1", 32'(perf_stall1), 32'd0);
    set0(1'b1, 32'h5, 5'd1, 2'b00, 4'h1);
    repeat (5) tick();
    set0(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
    rsp_ready = 1'b0;
    set1(1'b1, 32'h5, 5'd1, 2'b00, 4'h2);
    repeat (2) tick();
    set1(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
    rsp_ready = 1'b1;
    tick();
    chk("perf_grant0", 32'(perf_grant0), 32'd5);
    chk("perf_stall1", 32'(perf_stall1), 32'd2);
    chk("perf_grant1", 32'(perf_grant1), 32'd0);
    chk("perf_stall0", 32'(perf_stall0), 32'd0);
    set0(1'b1, 32'h5, 5'd1, 2'b00, 4'h1);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr_vs_grant", 32'(perf_grant0), 32'd0);
    repeat (70000) @(posedge clk);
    #1;
    chk("perf_sat", 32'(perf_grant0), 32'h0000_FFFF);
    set0(1'b0, 32'h0, 5'd0, 2'b00, 4'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
